serial_addsub_digit: RTL
========================

# serial_addsub_digit

Digit-serial two's-complement adder/subtractor for the sequential-arithmetic library. Each valid beat consumes one DIGIT_W-bit digit of both operands, LSB digit first, and produces one registered result digit. Words are framed by `vld`/`last`. The block also produces carry-out and signed overflow at the end of each word, and enforces a maximum word length. Typical placement is between a serial operand source and a serial result sink, for example a deserializer or a checker.

## Interface
- `DIGIT_W`, default 4: bits per beat; must be ≥ 1.
- `MAX_BEATS`, default 16: maximum beats per word; must be ≥ 1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `vld` input 1: the beat's inputs are valid.
- `sub` input 1: operation select, 0 = a+b, 1 = a−b. Sampled only on the first beat of a word.
- `a` input DIGIT_W: operand A digit.
- `b` input DIGIT_W: operand B digit.
- `last` input 1: final digit of the word. Ignored unless `vld` = 1.
- `sum_vld` output 1: the result digit is valid.
- `sum` output DIGIT_W: result digit.
- `sum_last` output 1: this result digit is the final digit of the word.
- `cout` output 1: carry out of the word's MSB. For subtraction, 1 means no borrow.
- `ovf` output 1: signed overflow of the word.
- `len_err` output 1: the word was force-terminated at MAX_BEATS.

## Operation
- **States.**
  - IDLE: expecting the first beat of a word.
  - BUSY: inside a word.
- **Per valid beat:**
  - `{c, s} = a + (b ^ {DIGIT_W{op}}) + cin`.
  - `op` is `sub` on the first beat and the latched `sub` on later beats.
  - `cin` is `op` on the first beat and the stored carry on later beats.
- **First beat (IDLE & vld):**
  - Latch `sub`.
  - Set the beat count to 1.
  - Go to BUSY, unless the beat ends the word.
- **Later beats (BUSY & vld):**
  - Store `c`.
  - Increment the beat count.
  - `sub` is ignored.
- **End of word:** a beat ends the word when `last` = 1, or when the beat count reaches MAX_BEATS.
  - On end of word: clear the carry and the count, return to IDLE.
  - `cout` = c of this beat.
  - `ovf` = carry into the MSB bit of this digit XOR carry out of it.
- **Single-beat word.** `last` on the first beat is legal. The word uses `cin` = `sub` and ends immediately.
- **Forced termination.** At the MAX_BEATS-th beat with `last` = 0, the word still ends, with `sum_last` = 1 and `len_err` = 1. The next valid beat starts a new word.
- **Idle cycles.** `vld` = 0: state, carry, count and the latched op all hold. A `last` asserted with `vld` = 0 has no effect.
- **Reset.** `rst` mid-word discards the word: IDLE, carry 0, count 0. No `sum_last` is emitted for the discarded word.
- **Output reset values:** `sum_vld`, `sum_last` and `len_err` are 0; `sum`, `cout` and `ovf` are 0.

## Timing
- Latency is 1 cycle: the beat presented at edge N appears on the outputs after edge N, with `sum_vld` = 1.
- `sum_vld`, `sum_last` and `len_err` are single-cycle pulses. `sum_last` and `len_err` are 0 whenever `sum_vld` = 0.
- `sum` updates only on valid beats and holds otherwise.
- `cout` and `ovf` update only on end-of-word beats, aligned with `sum_last`, and hold until the next end of word.
- Throughput is one beat per cycle. Back-to-back words need no gap: a `last` beat can be followed immediately by the next word's first beat.
- `rst` takes priority over `vld` in the same cycle.

## Structure
- **Shared package `serial_arith_pkg`:**
  - State enum (IDLE, BUSY).
  - Function `cnt_w(MAX_BEATS)` returning `$clog2(MAX_BEATS+1)`.
- **Sub-module `digit_add`:** combinational DIGIT_W-bit adder.
  - Inputs: `a`, `b_eff`, `cin`.
  - Outputs: `s`, `c_out`, `c_msb_in`.
  - Instantiated once.
- The top level holds the FSM, carry register, op latch, beat counter and output registers.

## Test plan
All scenarios use DIGIT_W = 4 and MAX_BEATS = 16 unless noted; digits are listed LSB first.
- **Multi-digit add.** a = 4,3,2,1 and b = F,F,F,0 with sub = 0, `last` on beat 4 → sum digits 3,3,2,2 (0x2233), `cout` = 0, `ovf` = 0, `sum_last` on the 4th output.
- **Subtract with borrow.** a = 5,0 and b = 7,0 with sub = 1, `last` on beat 2 → sum 0xFE (digits E,F), `cout` = 0, `ovf` = 0.
- **Signed overflow.** a = 0,7 and b = 0,1 with sub = 0 → sum 0x80, `ovf` = 1, `cout` = 0.
- **Idle gaps.** Repeat the multi-digit add with 2 idle cycles between beats. Toggle `sub` on beat 2 and assert `last` during an idle cycle → identical results, with exactly 4 `sum_vld` pulses.
- **Length limit.** MAX_BEATS = 4; send 5 beats of 1+1 with no `last` → output 4 has `sum_last` = 1 and `len_err` = 1; output 5 starts a new word with `cin` = 0, so its sum is 2.
- **Reset mid-word.** Beats F+1 and F+0 leave the carry at 1. Assert `rst`, then send a single beat 1+1 with `last` → sum = 2, `cout` = 0, and no `sum_last` pulse for the aborted word.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the digit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int cnt_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/digit_add.sv
// Combinational DIGIT_W-bit adder that also exposes the carry into its MSB.
module digit_add #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b_eff,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               c_out,
    output logic               c_msb_in
);

    logic [DIGIT_W:0] full;

    // The carry into the MSB is recovered from the MSB sum bit, which also holds for DIGIT_W = 1.
    always_comb begin
        full     = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
        s        = full[DIGIT_W-1:0];
        c_out    = full[DIGIT_W];
        c_msb_in = a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ full[DIGIT_W-1];
    end

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, with word framing and length limit.
module serial_addsub_digit
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W   = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic               sub,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               last,
    output logic               sum_vld,
    output logic [DIGIT_W-1:0] sum,
    output logic               sum_last,
    output logic               cout,
    output logic               ovf,
    output logic               len_err
);

    localparam int CNT_W = cnt_w(MAX_BEATS);

    state_t             state_q, state_d;
    logic               carry_q, carry_d;
    logic               op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sum_vld_q, sum_vld_d;
    logic [DIGIT_W-1:0] sum_q, sum_d;
    logic               sum_last_q, sum_last_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               len_err_q, len_err_d;

    logic               first;
    logic               op;
    logic               cin;
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W-1:0] s;
    logic               c;
    logic               c_msb_in;
    logic [CNT_W-1:0]   cnt_next;
    logic               hit_max;
    logic               eow;

    digit_add #(
        .DIGIT_W (DIGIT_W)
    ) u_add (
        .a        (a),
        .b_eff    (b_eff),
        .cin      (cin),
        .s        (s),
        .c_out    (c),
        .c_msb_in (c_msb_in)
    );

    // On the first beat the live sub input supplies both the operation and the +1 of the negation.
    always_comb begin
        first    = (state_q == IDLE);
        op       = first ? sub : op_q;
        cin      = first ? sub : carry_q;
        b_eff    = b ^ {DIGIT_W{op}};
        cnt_next = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
        hit_max  = (cnt_next == CNT_W'(MAX_BEATS));
        eow      = last | hit_max;

        state_d    = state_q;
        carry_d    = carry_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        sum_vld_d  = 1'b0;
        sum_d      = sum_q;
        sum_last_d = 1'b0;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        len_err_d  = 1'b0;

        if (vld) begin
            sum_vld_d = 1'b1;
            sum_d     = s;
            if (first) begin
                op_d = sub;
            end
            if (eow) begin
                state_d    = IDLE;
                carry_d    = 1'b0;
                cnt_d      = '0;
                sum_last_d = 1'b1;
                len_err_d  = ~last;
                cout_d     = c;
                ovf_d      = c_msb_in ^ c;
            end else begin
                state_d = BUSY;
                carry_d = c;
                cnt_d   = cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            carry_q    <= 1'b0;
            op_q       <= 1'b0;
            cnt_q      <= '0;
            sum_vld_q  <= 1'b0;
            sum_q      <= '0;
            sum_last_q <= 1'b0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            carry_q    <= carry_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            sum_vld_q  <= sum_vld_d;
            sum_q      <= sum_d;
            sum_last_q <= sum_last_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            len_err_q  <= len_err_d;
        end
    end

    assign sum_vld  = sum_vld_q;
    assign sum      = sum_q;
    assign sum_last = sum_last_q;
    assign cout     = cout_q;
    assign ovf      = ovf_q;
    assign len_err  = len_err_q;

endmodule
